// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   Four-digit BCD stopwatch with a start/stop button and a clear button.
//   A prescaler divides clk by TICK_DIV to produce count increments; the
//   count ripples through four decimal digits and wraps 9999 -> 0000,
//   latching a sticky overflow flag.
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   btn_ss     start/stop request (asynchronous, active-high)
//   btn_clr    clear request (asynchronous, active-high, level)
//   dig0..dig3 BCD digits: units, tens, hundreds, thousands
//   running    high while the stopwatch is in RUN
//   ovf        sticky flag, set by a 9999 -> 0000 wrap
module bcd_stopwatch #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } stateT;

  stateT r_state;
  stateT w_stateNext;

  logic r_ssS1, r_ssS2, r_ssPrev;
  logic r_clrS1, r_clrS2;
  logic [1:0] r_fill;
  logic r_ssArmed;
  logic w_ssEdge, w_clr;

  logic [PW-1:0] r_presc;
  logic [3:0] r_dig0, r_dig1, r_dig2, r_dig3;
  logic r_ovf, r_running;
  logic w_stayRun, w_tick, w_allNines;

  // Button synchronizers. r_fill marks when s2 holds a genuine post-reset
  // sample; start/stop edges are only accepted once btn_ss has been seen
  // low after that, so a button held through reset release cannot start us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssS1    <= 1'b0;
      r_ssS2    <= 1'b0;
      r_ssPrev  <= 1'b0;
      r_clrS1   <= 1'b0;
      r_clrS2   <= 1'b0;
      r_fill    <= 2'b00;
      r_ssArmed <= 1'b0;
    end else begin
      r_ssS1   <= btn_ss;
      r_ssS2   <= r_ssS1;
      r_ssPrev <= r_ssS2;
      r_clrS1  <= btn_clr;
      r_clrS2  <= r_clrS1;
      r_fill   <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_ssS2) begin
        r_ssArmed <= 1'b1;
      end
    end
  end

  assign w_ssEdge = r_ssS2 & ~r_ssPrev & r_ssArmed;
  assign w_clr    = r_clrS2;

  // State register; running is registered from the next state so it
  // equals (state == RUN) after every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_running <= (w_stateNext == RUN);
    end
  end

  // Next-state logic: clear overrides and masks any start/stop edge.
  always_comb begin
    w_stateNext = r_state;
    if (w_clr) begin
      w_stateNext = IDLE;
    end else if (w_ssEdge) begin
      case (r_state)
        IDLE:    w_stateNext = RUN;
        RUN:     w_stateNext = PAUSE;
        PAUSE:   w_stateNext = RUN;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Counting controls: only an edge that both starts and ends in RUN
  // advances the prescaler, so the RUN->PAUSE edge never increments.
  always_comb begin
    w_stayRun  = (r_state == RUN) && (w_stateNext == RUN);
    w_tick     = w_stayRun && (r_presc == PRESC_MAX);
    w_allNines = (r_dig0 == 4'd9) && (r_dig1 == 4'd9) &&
                 (r_dig2 == 4'd9) && (r_dig3 == 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (w_stayRun) begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Decimal ripple counter with sticky overflow on the 9999 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig0 <= 4'd0;
      r_dig1 <= 4'd0;
      r_dig2 <= 4'd0;
      r_dig3 <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (w_clr) begin
      r_dig0 <= 4'd0;
      r_dig1 <= 4'd0;
      r_dig2 <= 4'd0;
      r_dig3 <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (w_tick) begin
      if (w_allNines) begin
        r_ovf <= 1'b1;
      end
      if (r_dig0 != 4'd9) begin
        r_dig0 <= r_dig0 + 4'd1;
      end else begin
        r_dig0 <= 4'd0;
        if (r_dig1 != 4'd9) begin
          r_dig1 <= r_dig1 + 4'd1;
        end else begin
          r_dig1 <= 4'd0;
          if (r_dig2 != 4'd9) begin
            r_dig2 <= r_dig2 + 4'd1;
          end else begin
            r_dig2 <= 4'd0;
            if (r_dig3 != 4'd9) begin
              r_dig3 <= r_dig3 + 4'd1;
            end else begin
              r_dig3 <= 4'd0;
            end
          end
        end
      end
    end
  end

  assign dig0    = r_dig0;
  assign dig1    = r_dig1;
  assign dig2    = r_dig2;
  assign dig3    = r_dig3;
  assign running = r_running;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
//   Directed bench for bcd_stopwatch with TICK_DIV = 4. The stimulus
//   process drives the buttons and pushes hand-computed expected outputs,
//   tagged with the clock edge after which they must hold, into a queue.
//   A monitor process pops entries as their edge comes up and compares.
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;

  logic clk;
  logic rst_n;
  logic btn_ss;
  logic btn_clr;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic running;
  logic ovf;

  typedef struct {
    int          cycle;
    string       name;
    logic [15:0] digits;
    logic        run;
    logic        ovf;
  } expT;

  expT expQ[$];
  int  cycleCount = 0;
  int  vectorCount = 0;
  int  missCount = 0;
  bit  stimDone = 1'b0;

  bcd_stopwatch #(.TICK_DIV(TICK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3),
    .running (running),
    .ovf     (ovf)
  );

  // Free-running clock and a count of rising edges seen so far.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  task automatic goTo(input int c);
    while (cycleCount < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ss, input logic clr);
    btn_ss  = ss;
    btn_clr = clr;
  endtask

  task automatic expectOutput(input int c, input string name,
                              input logic [15:0] d, input logic r,
                              input logic o);
    expT e;
    e.cycle  = c;
    e.name   = name;
    e.digits = d;
    e.run    = r;
    e.ovf    = o;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    logic [15:0] act;
    act = {dig3, dig2, dig1, dig0};
    vectorCount++;
    if (e.cycle != cycleCount || act !== e.digits ||
        running !== e.run || ovf !== e.ovf) begin
      missCount++;
      $display("[TB] FAIL %s at edge %0d (due %0d): got digits=%h running=%b ovf=%b, expected digits=%h running=%b ovf=%b",
               e.name, cycleCount, e.cycle, act, running, ovf,
               e.digits, e.run, e.ovf);
    end
  endtask

  // Stimulus with expected responses computed by hand for TICK_DIV = 4.
  initial begin : stimulus
    int a, b, c, d, e;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    a = cycleCount;
    expectOutput(a + 1, "reset", 16'h0000, 1'b0, 1'b0);
    goTo(a + 1);
    rst_n = 1'b1;

    // Start: 5-cycle press, one transition, increments every 4 edges.
    b = a + 6;
    goTo(b);
    applyStimulus(1'b1, 1'b0);
    expectOutput(b + 2, "start_latency", 16'h0000, 1'b0, 1'b0);
    expectOutput(b + 3, "start", 16'h0000, 1'b1, 1'b0);
    expectOutput(b + 6, "first_tick_wait", 16'h0000, 1'b1, 1'b0);
    expectOutput(b + 7, "first_tick", 16'h0001, 1'b1, 1'b0);
    goTo(b + 5);
    applyStimulus(1'b0, 1'b0);
    expectOutput(b + 10, "second_tick_wait", 16'h0001, 1'b1, 1'b0);
    expectOutput(b + 11, "second_tick", 16'h0002, 1'b1, 1'b0);
    expectOutput(b + 15, "third_tick", 16'h0003, 1'b1, 1'b0);
    expectOutput(b + 30, "count6", 16'h0006, 1'b1, 1'b0);
    expectOutput(b + 31, "count7", 16'h0007, 1'b1, 1'b0);

    // Pause lands on the edge where the prescaler sits at its maximum.
    goTo(b + 32);
    applyStimulus(1'b1, 1'b0);
    expectOutput(b + 34, "prepause", 16'h0007, 1'b1, 1'b0);
    expectOutput(b + 35, "pause_no_inc", 16'h0007, 1'b0, 1'b0);
    goTo(b + 35);
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      expectOutput(b + 35 + k, "frozen", 16'h0007, 1'b0, 1'b0);
    end

    // Resume: held prescaler means the very next RUN edge increments.
    goTo(b + 75);
    applyStimulus(1'b1, 1'b0);
    expectOutput(b + 77, "resume_latency", 16'h0007, 1'b0, 1'b0);
    expectOutput(b + 78, "resume", 16'h0007, 1'b1, 1'b0);
    expectOutput(b + 79, "resume_remaining", 16'h0008, 1'b1, 1'b0);
    goTo(b + 78);
    applyStimulus(1'b0, 1'b0);

    // After resume, count v appears at edge b + 47 + 4v.
    expectOutput(b + 82, "count8", 16'h0008, 1'b1, 1'b0);
    expectOutput(b + 83, "count9", 16'h0009, 1'b1, 1'b0);
    expectOutput(b + 87, "carry10", 16'h0010, 1'b1, 1'b0);
    expectOutput(b + 443, "count99", 16'h0099, 1'b1, 1'b0);
    expectOutput(b + 446, "count99_hold", 16'h0099, 1'b1, 1'b0);
    expectOutput(b + 447, "carry100", 16'h0100, 1'b1, 1'b0);
    expectOutput(b + 40042, "count9998", 16'h9998, 1'b1, 1'b0);
    expectOutput(b + 40043, "count9999", 16'h9999, 1'b1, 1'b0);
    expectOutput(b + 40046, "count9999_hold", 16'h9999, 1'b1, 1'b0);
    expectOutput(b + 40047, "wrap", 16'h0000, 1'b1, 1'b1);
    expectOutput(b + 40051, "ovf_sticky1", 16'h0001, 1'b1, 1'b1);
    expectOutput(b + 40055, "ovf_sticky2", 16'h0002, 1'b1, 1'b1);
    c = b + 40539;
    expectOutput(c - 1, "count122", 16'h0122, 1'b1, 1'b1);
    expectOutput(c, "count123", 16'h0123, 1'b1, 1'b1);

    // Start/stop and clear rise together: clear wins, nothing restarts.
    goTo(c);
    applyStimulus(1'b1, 1'b1);
    expectOutput(c + 2, "preclear", 16'h0123, 1'b1, 1'b1);
    expectOutput(c + 3, "clear", 16'h0000, 1'b0, 1'b0);
    goTo(c + 5);
    applyStimulus(1'b1, 1'b0);
    goTo(c + 10);
    applyStimulus(1'b0, 1'b0);
    for (int k = 11; k <= 14; k++) begin
      expectOutput(c + k, "no_start", 16'h0000, 1'b0, 1'b0);
    end

    // Fresh run up to 0456, then an asynchronous reset between edges.
    d = c + 14;
    goTo(d);
    applyStimulus(1'b1, 1'b0);
    expectOutput(d + 2, "restart_latency", 16'h0000, 1'b0, 1'b0);
    expectOutput(d + 3, "restart", 16'h0000, 1'b1, 1'b0);
    goTo(d + 4);
    applyStimulus(1'b0, 1'b0);
    e = d + 3 + 4 * 456;
    expectOutput(d + 7, "restart_tick", 16'h0001, 1'b1, 1'b0);
    expectOutput(e - 1, "count455", 16'h0455, 1'b1, 1'b0);
    expectOutput(e, "count456", 16'h0456, 1'b1, 1'b0);
    goTo(e);
    expectOutput(e + 1, "async_reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0);
    goTo(e + 2);
    for (int k = 3; k <= 10; k++) begin
      expectOutput(e + k, "held_at_release", 16'h0000, 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b1;
    goTo(e + 8);
    applyStimulus(1'b0, 1'b0);
    goTo(e + 12);
    applyStimulus(1'b1, 1'b0);
    expectOutput(e + 14, "rearm_latency", 16'h0000, 1'b0, 1'b0);
    expectOutput(e + 15, "rearm_start", 16'h0000, 1'b1, 1'b0);
    expectOutput(e + 19, "rearm_tick", 16'h0001, 1'b1, 1'b0);
    goTo(e + 16);
    applyStimulus(1'b0, 1'b0);
    stimDone = 1'b1;
  end

  // Monitor: compares every queued expectation on the falling edge after
  // its rising edge, then drains and reports.
  initial begin : monitor
    int drain;
    drain = 0;
    while (!(stimDone && expQ.size() == 0) && drain < 50) begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].cycle <= cycleCount) begin
        checkOutput(expQ.pop_front());
      end
      if (stimDone) drain++;
    end
    if (expQ.size() != 0) begin
      missCount += expQ.size();
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0",
               expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per count increment (100 Hz at 50 MHz); legal range >= 2.
REQ-002 The module SHALL have port clk, input, 1, meaning the single system clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-004 The module SHALL have port btn_ss, input, 1, meaning start/stop request, active-high, asynchronous to clk.
REQ-005 The module SHALL have port btn_clr, input, 1, meaning clear request, active-high, level-sensitive, asynchronous to clk.
REQ-006 The module SHALL have ports dig0, dig1, dig2, dig3, output, 4 each, meaning BCD digits (units, tens, hundreds, thousands) driven straight into one 7-segment decoder each.
REQ-007 The module SHALL have port running, output, 1, meaning high while in state RUN.
REQ-008 The module SHALL have port ovf, output, 1, meaning sticky flag for a 9999->0000 wrap.
REQ-009 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Function
REQ-010 btn_ss and btn_clr SHALL each pass through a 2-flop synchronizer (s1, s2); btn_ss SHALL add a third flop (prev) for edge detection.
REQ-011 An ss edge SHALL be s2 high and prev low; a clr level SHALL be s2 of btn_clr high.
REQ-012 Latency SHALL be: input high first sampled at edge N -> state/digit effect visible after edge N+2, for both ss edge and clr.
REQ-013 The FSM SHALL have states IDLE, RUN and PAUSE; IDLE SHALL be the reset state.
REQ-014 FSM transitions SHALL be: IDLE -ss edge-> RUN; RUN -ss edge-> PAUSE; PAUSE -ss edge-> RUN.
REQ-015 Any state -clr-> IDLE.
REQ-016 clr SHALL take priority over an ss edge in the same cycle, and an ss edge SHALL be ignored while clr is high.
REQ-017 Holding btn_ss high SHALL produce exactly one transition; a new edge SHALL require btn_ss to return low first.
REQ-018 The prescaler (width ceil(log2(TICK_DIV))) SHALL count 0..TICK_DIV-1 only in RUN.
REQ-019 The prescaler SHALL hold its value in PAUSE and be 0 in IDLE.
REQ-020 On an edge where state is RUN and prescaler == TICK_DIV-1, the prescaler SHALL wrap to 0 and the 4-digit count SHALL increment by one in that same edge.
REQ-021 The first increment after IDLE->RUN SHALL occur TICK_DIV cycles after the transition edge; in steady RUN, increments SHALL occur exactly every TICK_DIV cycles.
REQ-022 The increment SHALL be a decimal ripple: dig0 9->0 carries into dig1, and so on; every digit SHALL stay within 0..9 at all times.
REQ-023 An increment from 9999 SHALL give 0000, set ovf to 1 on that edge and keep counting; ovf SHALL be cleared only by clr or reset.
REQ-024 The RUN->PAUSE transition edge SHALL NOT increment, even if the prescaler is at TICK_DIV-1.
REQ-025 On resume, the prescaler SHALL continue from its held value.
REQ-026 clr SHALL zero the digits, prescaler and ovf on the same edge that enters IDLE.
REQ-027 running SHALL be registered and SHALL equal (state == RUN) after each edge.

Reset
REQ-028 While rst_n is low, state = IDLE, dig0..dig3 = 0, prescaler = 0, ovf = 0, running = 0, and all synchronizer flops = 0, all asynchronously.
REQ-029 Deassertion of rst_n mid-count SHALL resume from IDLE with zeros.
REQ-030 A btn_ss already high at rst_n release SHALL NOT generate an ss edge until it has been seen low after reset.

Verification (TICK_DIV = 4)
REQ-031 Reset, then btn_ss pulse high for 5 cycles -> running = 1 after 3rd edge; digits 0001 after 4 more edges, 0002 after 4 more; exactly one transition.
REQ-032 Run to 0007, then btn_ss pulse -> running = 0, digits frozen at 0007 for 40 cycles; second pulse -> running = 1, next increment spaced by remaining prescaler count.
REQ-033 Count through 0009 -> 0010 and 0099 -> 0100, then force 9999 -> next tick gives 0000 with ovf = 1; ovf stays 1 through further ticks.
REQ-034 btn_ss and btn_clr rise in the same cycle during RUN at 0123 -> IDLE, 0000, ovf = 0, running = 0; no start occurs.
REQ-035 rst_n pulsed low asynchronously between clk edges during RUN at 0456 -> all outputs 0 immediately; with btn_ss held high across release -> stays IDLE until btn_ss low then high.
